// File: rtl/uart_232_rx.sv
`timescale 1ns/1ps
// uart_232_rx: 8N1 serial receiver with start validation, stop check and frame-error reporting.
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   uart_rx    asynchronous serial line, idles high
//   bit_set    baud select (0=9600 1=19200 2=38400 3=57600 4=115200 5..7=9600)
//   data       last correctly framed byte
//   rx_done    one-cycle pulse when data updates
//   frame_err  one-cycle pulse when the stop bit samples low
//   busy       high whenever the receiver is not idle
// Optional feature: define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around bit centre.
module uart_232_rx #(
    parameter int clk_freq = 50_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       uart_rx,
    input  logic [2:0] bit_set,
    output logic [7:0] data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       busy
);
    localparam logic [15:0] T0 = 16'(clk_freq / 9600);
    localparam logic [15:0] T1 = 16'(clk_freq / 19200);
    localparam logic [15:0] T2 = 16'(clk_freq / 38400);
    localparam logic [15:0] T3 = 16'(clk_freq / 57600);
    localparam logic [15:0] T4 = 16'(clk_freq / 115200);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
    state_t state, state_n;
    logic        rx_m, line_s, line_d;
    logic [2:0]  baud_q;
    logic [15:0] bit_cnt, bit_time, bit_half;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        bit_end, samp_pt, samp_val, done_n, err_n;
    assign bit_time = baud_q == 3'd1 ? T1 : baud_q == 3'd2 ? T2 : baud_q == 3'd3 ? T3 :
                      baud_q == 3'd4 ? T4 : T0;
    assign bit_half = bit_time >> 1;
    assign bit_end  = bit_cnt == bit_time - 16'd1;
    assign busy     = state != IDLE;
`ifdef UART_RX_MAJORITY_EN
    logic [15:0] bit_q3;
    logic        m1, m2;
    assign bit_q3   = bit_time >> 3;
    // decision is taken at the third sample, using the two earlier captures
    assign samp_pt  = bit_cnt == bit_half + bit_q3;
    assign samp_val = (m1 & m2) | (m1 & line_s) | (m2 & line_s);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            m1 <= 1'b1;
            m2 <= 1'b1;
        end else begin
            if (bit_cnt == bit_half - bit_q3) m1 <= line_s;
            if (bit_cnt == bit_half) m2 <= line_s;
        end
`else
    assign samp_pt  = bit_cnt == bit_half;
    assign samp_val = line_s;
`endif
    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE:  state_n = (!line_s && line_d) ? START : IDLE;
            START: state_n = (samp_pt && samp_val) ? IDLE : bit_end ? DATA : START;
            DATA:  state_n = (bit_end && bit_idx == 3'd7) ? STOP : DATA;
            STOP: begin
                state_n = samp_pt ? (samp_val ? IDLE : BRK) : STOP;
                done_n  = samp_pt && samp_val;
                err_n   = samp_pt && !samp_val;
            end
            BRK:   state_n = line_s ? IDLE : BRK;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            rx_m      <= 1'b1;
            line_s    <= 1'b1;
            line_d    <= 1'b1;
            state     <= IDLE;
            baud_q    <= 3'd0;
            bit_cnt   <= 16'd0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            data      <= 8'h00;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_m      <= uart_rx;
            line_s    <= rx_m;
            line_d    <= line_s;
            state     <= state_n;
            rx_done   <= done_n;
            frame_err <= err_n;
            if (done_n) data <= shift;
            if (state == IDLE) begin
                bit_cnt <= 16'd0;
                if (state_n == START) baud_q <= bit_set;
            end else begin
                bit_cnt <= bit_end ? 16'd0 : bit_cnt + 16'd1;
            end
            if (state == START) bit_idx <= 3'd0;
            else if (state == DATA && bit_end) bit_idx <= bit_idx + 3'd1;
            if (state == DATA && samp_pt) shift[bit_idx] <= samp_val;
        end
endmodule

// File: tb/tb_uart_232_rx.sv
`timescale 1ns/1ps
// tb_uart_232_rx: directed checks of framing, timing, false start, break, baud latch, reset and glitch handling.
module tb_uart_232_rx;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    logic       clk, reset_n, uart_rx;
    logic [2:0] bit_set;
    logic [7:0] data;
    logic       rx_done, frame_err, busy;
    int checks = 0, errors = 0, cyc = 0;
    int n_done = 0, n_err = 0, n_wide = 0, n_both = 0, err_cyc = 0, fall_cyc = 0;
    int done_cyc[16];
    logic [7:0] done_dat[16];
    logic prev_done = 1'b0, prev_err = 1'b0, prev_busy = 1'b0;
    int t0, n0, e0;

    uart_232_rx dut (
        .clk(clk), .reset_n(reset_n), .uart_rx(uart_rx), .bit_set(bit_set),
        .data(data), .rx_done(rx_done), .frame_err(frame_err), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_done) begin
            if (n_done < 16) begin
                done_cyc[n_done] = cyc;
                done_dat[n_done] = data;
            end
            n_done++;
        end
        if (frame_err) begin
            n_err++;
            err_cyc = cyc;
        end
        if ((rx_done && prev_done) || (frame_err && prev_err)) n_wide++;
        if (rx_done && frame_err) n_both++;
        if (prev_busy && !busy) fall_cyc = cyc;
        prev_done = rx_done;
        prev_err  = frame_err;
        prev_busy = busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // drives start, 8 data bits LSB first and stop, each held bt cycles; gl forces one low cycle in bit 3
    task automatic send(input logic [7:0] b, input logic stop, input int bt, input int gl);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < bt; j++) begin
                uart_rx = (i == 4 && j == gl) ? 1'b0 : fr[i];
                @(negedge clk);
            end
    endtask

    initial begin
        reset_n = 1'b0;
        uart_rx = 1'b1;
        bit_set = 3'd4;
        repeat (3) @(negedge clk);
        chk("reset_data", 32'(data), 32'h00);
        chk("reset_rx_done", 32'(rx_done), 0);
        chk("reset_frame_err", 32'(frame_err), 0);
        chk("reset_busy", 32'(busy), 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // 115200, 0x55
        t0 = cyc; n0 = n_done; e0 = n_err;
        send(8'h55, 1'b1, 434, -1);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("t1_done_count", 32'(n_done - n0), 1);
        chk("t1_done_data", 32'(done_dat[n0]), 32'h55);
        chk("t1_done_time", 32'(done_cyc[n0] - t0), 32'(4 + 9 * 434 + 217 + MAJ * 54));
        chk("t1_data", 32'(data), 32'h55);
        chk("t1_no_err", 32'(n_err - e0), 0);

        // 9600, false start
        bit_set = 3'd0;
        t0 = cyc; n0 = n_done; e0 = n_err;
        uart_rx = 1'b0;
        repeat (100) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3500) @(negedge clk);
        chk("t2_busy_fall", 32'(fall_cyc - t0), 32'(3 + 2604 + 1 + MAJ * 651));
        chk("t2_no_done", 32'(n_done - n0), 0);
        chk("t2_no_err", 32'(n_err - e0), 0);

        // 38400, 0xA3 with low stop then held low
        bit_set = 3'd2;
        t0 = cyc; n0 = n_done; e0 = n_err;
        send(8'hA3, 1'b0, 1302, -1);
        repeat (2604) @(negedge clk);
        chk("t3_err_count", 32'(n_err - e0), 1);
        chk("t3_err_time", 32'(err_cyc - t0), 32'(4 + 9 * 1302 + 651 + MAJ * 162));
        chk("t3_busy_in_break", 32'(busy), 1);
        uart_rx = 1'b1;
        repeat (10) @(negedge clk);
        chk("t3_idle_after_high", 32'(busy), 0);
        chk("t3_data_kept", 32'(data), 32'h55);
        chk("t3_no_done", 32'(n_done - n0), 0);

        // 57600, back-to-back 0x00 and 0xFF
        bit_set = 3'd3;
        n0 = n_done;
        send(8'h00, 1'b1, 868, -1);
        send(8'hFF, 1'b1, 868, -1);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("t4_done_count", 32'(n_done - n0), 2);
        chk("t4_first", 32'(done_dat[n0]), 32'h00);
        chk("t4_second", 32'(done_dat[n0 + 1]), 32'hFF);
        chk("t4_spacing", 32'(done_cyc[n0 + 1] - done_cyc[n0]), 32'(10 * 868));
        chk("t4_data", 32'(data), 32'hFF);

        // baud select changed mid-frame
        bit_set = 3'd4;
        t0 = cyc; n0 = n_done;
        fork
            send(8'h96, 1'b1, 434, -1);
            begin
                repeat (1000) @(negedge clk);
                bit_set = 3'd0;
            end
        join
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("t5_data", 32'(data), 32'h96);
        chk("t5_done_time", 32'(done_cyc[n0] - t0), 32'(4 + 9 * 434 + 217 + MAJ * 54));

        // reset during data bit 4
        bit_set = 3'd4;
        n0 = n_done; e0 = n_err;
        fork
            send(8'hF0, 1'b1, 434, -1);
            begin
                repeat (5 * 434 + 200) @(negedge clk);
                reset_n = 1'b0;
                repeat (3) @(negedge clk);
                chk("t6_rst_data", 32'(data), 32'h00);
                chk("t6_rst_rx_done", 32'(rx_done), 0);
                chk("t6_rst_frame_err", 32'(frame_err), 0);
                chk("t6_rst_busy", 32'(busy), 0);
                reset_n = 1'b1;
            end
        join
        uart_rx = 1'b1;
        repeat (50) @(negedge clk);
        chk("t6_no_pulse", 32'((n_done - n0) + (n_err - e0)), 0);
        chk("t6_data_after", 32'(data), 32'h00);
        send(8'h3C, 1'b1, 434, -1);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("t6_next_frame", 32'(data), 32'h3C);

        // one-cycle glitch at centre of bit 3
        send(8'hFF, 1'b1, 434, 218);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("t7_glitch", 32'(data), MAJ == 1 ? 32'hFF : 32'hF7);

        chk("pulse_width", 32'(n_wide), 0);
        chk("pulse_overlap", 32'(n_both), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_232_rx.md
# uart_232_rx

Serial receiver that pairs with the 8N1 transmitter on the same board link. It samples the incoming `uart_rx` line, detects and validates the start bit, and shifts in 8 data bits LSB first. It checks the stop bit, then presents the byte on `data` with a one-cycle `rx_done` strobe. Baud-rate selection uses the same `bit_set` encoding as the transmitter, so both ends are configured from one register field.

## Interface
- `clk_freq`, default 50_000_000: system clock frequency in Hz.
- `clk`  input  1  system clock; all logic on rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `uart_rx`  input  1  asynchronous serial line; idles high.
- `bit_set`  input  3  baud select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200, 5–7=9600.
- `data`  output  8  last correctly framed byte; holds until the next good frame.
- `rx_done`  output  1  one-cycle pulse when `data` updates.
- `frame_err`  output  1  one-cycle pulse when the stop bit samples low.
- `busy`  output  1  high in any state other than IDLE.

## Operation
- `bit_time = clk_freq/baud` (integer divide). For 50 MHz: 5208/2604/1302/868/434.
- `bit_half = bit_time>>1`.
- Width rules:
  - `bit_cnt` is 16-bit and counts 0..`bit_time`-1, then wraps to 0.
  - `bit_idx` is 3-bit.
- Input sync:
  - Two flops, both reset to 1. `line_s` is the second stage. `line_d` is `line_s` delayed by one cycle.
  - All decisions use `line_s` only.
- `bit_set` is latched into `baud_q` on start detection. Changes mid-frame have no effect until the next frame.
- State IDLE:
  - Exit when `line_s`=0 and `line_d`=1 (falling edge).
  - On exit: go to START, clear `bit_cnt` to 0, latch `baud_q`.
  - A line that is already low after reset or after BRK does not trigger a start.
- State START:
  - At the sample point (`bit_cnt`==`bit_half`), if the sampled value is 1: false start, go to IDLE, no pulses.
  - Otherwise continue. When `bit_cnt`==`bit_time`-1, go to DATA with `bit_idx`=0.
- State DATA:
  - At each sample point, store the sampled value into `shift[bit_idx]`.
  - At each `bit_time`-1, increment `bit_idx`. After bit 7, go to STOP.
- State STOP, at the sample point:
  - Sample 1: load `data` from `shift`, pulse `rx_done`, go to IDLE.
  - Sample 0: pulse `frame_err`, leave `data` unchanged, go to BRK.
- State BRK: wait for `line_s`=1, then go to IDLE. No start is detected while in BRK.
- `rx_done` and `frame_err` are never high in the same cycle.
- Reset values: `data`=0x00, `rx_done`=0, `frame_err`=0, `busy`=0, state=IDLE, `bit_cnt`=0, `bit_idx`=0.
- Reset asserted mid-frame aborts immediately: no pulse, all registers return to their reset values.

## Timing
- Line-to-`line_s` latency: 2 cycles.
- Start detection happens 1 cycle after `line_s` falls. That is cycle S, where `bit_cnt`=0 in START.
- Data bit k is sampled at S + (k+1)·`bit_time` + `bit_half`.
- `rx_done` / `frame_err` rise on the edge after the stop sample point: S + 9·`bit_time` + `bit_half` + 1. Both last exactly one cycle.
- `data` changes on the same edge that `rx_done` rises.
- IDLE is re-entered mid-stop-bit. A start edge arriving immediately after the stop bit (zero idle gap) is therefore caught.
- `busy` rises at S and falls on the edge that returns to IDLE.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Each sample point takes three samples of `line_s`, at `bit_half`-`(bit_time>>3)`, `bit_half`, and `bit_half`+`(bit_time>>3)`.
  - The sampled value is the 2-of-3 majority, evaluated at the last of the three samples.
  - Every decision and pulse described above shifts to that third sample; pulses come `bit_time>>3` cycles later than without the macro.
- Not defined: the sampled value is the single `line_s` value at `bit_half`.

## Test plan
- 115200 baud, send 0x55, clean stop bit.
  - `rx_done` is high for exactly 1 cycle, `data`=0x55.
  - Pulse timing matches the Timing formula (±0 cycles, plus `bit_time>>3` with the macro defined).
- 9600 baud, line low for 100 cycles then high.
  - No `rx_done` and no `frame_err`.
  - `busy` falls at the START sample point.
- 38400 baud, byte 0xA3 with stop bit driven low, line held low for 2 more bit times, then high.
  - Single `frame_err` pulse; `data` keeps the previous value.
  - No start is detected until the line returns high.
- 57600 baud, frames 0x00 then 0xFF back-to-back with zero idle gap.
  - Two `rx_done` pulses, `data`=0x00 then 0xFF.
- Change `bit_set` from 4 to 0 mid-frame: the current byte is received correctly at 115200.
- Assert `reset_n` during data bit 4: all outputs at their reset values, no pulse. The next full frame (0x3C) is received correctly.
- Macro defined: a 1-cycle low glitch at the centre of bit 3 of 0xFF still yields `data`=0xFF. With the macro undefined, the same stimulus yields 0xF7.
